multi_debounce: RTL and testbench

Parametrised N-channel switch/button debouncer. It synchronises each raw input, filters it with a per-channel state machine and hold-off counter, and produces a debounced level plus one-cycle rise and fall ticks for each channel. An optional long-press detector is compiled in with a macro. It sits between board switches/buttons and control logic, and is the multi-channel successor to the single-input debouncer.

---
 rtl/multi_debounce_if.sv | 27 ++
 rtl/multi_debounce.sv | 150 +++++++++++++++
 tb/tb_multi_debounce.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/multi_debounce_if.sv
// Signal bundle between raw switch inputs and the multi-channel debouncer.
// The master drives the raw switches; the slave (the debouncer) returns levels and ticks.
interface multi_debounce_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] rise_tick;
    logic [N_CH-1:0] fall_tick;
    logic [N_CH-1:0] long_tick;

    modport master (
        output sw,
        input  db_level,
        input  rise_tick,
        input  fall_tick,
        input  long_tick
    );

    modport slave (
        input  sw,
        output db_level,
        output rise_tick,
        output fall_tick,
        output long_tick
    );
endinterface

// File: rtl/multi_debounce.sv
// N-channel switch debouncer: 2-FF synchroniser, 4-state filter FSM and hold-off counter per channel.
// Optional long-press detector compiled in with `define DEBOUNCE_LONGPRESS_EN.
module multi_debounce #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 20,
    parameter int LP_W  = 26
) (
    input  logic             clk,
    input  logic             reset,
    multi_debounce_if.slave  bus
);

    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] ONE   = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (N_CH < 1 || N_CH > 32 || CNT_W < 1 || LP_W < 1) begin : g_bad_param
        $error("multi_debounce: parameter out of range");
    end

    logic [N_CH-1:0] level_v;
    logic [N_CH-1:0] rise_v;
    logic [N_CH-1:0] fall_v;
    logic [N_CH-1:0] long_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]       sync;
        logic             sw_s;
        logic [1:0]       state;
        logic [1:0]       state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             level;
        logic             rise;
        logic             fall;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync <= '0;
            end else begin
                sync <= {sync[0], bus.sw[i]};
            end
        end

        assign sw_s = sync[1];

        // NOTE: next-state values get a default before the case so no path leaves them unassigned (no latch).
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            case (state)
                ZERO: begin
                    if (sw_s) begin
                        state_next = WAIT1;
                        cnt_next   = CNT_MAX;
                    end
                end
                WAIT1: begin
                    if (!sw_s) begin
                        state_next = ZERO;
                    end else if (cnt == '0) begin
                        state_next = ONE;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                ONE: begin
                    if (!sw_s) begin
                        state_next = WAIT0;
                        cnt_next   = CNT_MAX;
                    end
                end
                WAIT0: begin
                    if (sw_s) begin
                        state_next = ONE;
                    end else if (cnt == '0) begin
                        state_next = ZERO;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                default: state_next = ZERO;
            endcase
        end

        // Ticks compare the current state against the previous registered level, so a
        // WAIT0->ONE bounce return (level already 1) never produces a rise tick.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= ZERO;
                cnt   <= '0;
                level <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
                level <= (state == ONE) || (state == WAIT0);
                rise  <= (state == ONE) && !level;
                fall  <= (state == ZERO) && level;
            end
        end

        assign level_v[i] = level;
        assign rise_v[i]  = rise;
        assign fall_v[i]  = fall;

`ifdef DEBOUNCE_LONGPRESS_EN
        logic [LP_W-1:0] lp_cnt;
        logic            lp_done;
        logic            long_q;

        // Counter saturates at all-ones; lp_done limits the tick to one per press.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lp_cnt  <= '0;
                lp_done <= 1'b0;
                long_q  <= 1'b0;
            end else if (state == ZERO || state == WAIT1) begin
                lp_cnt  <= '0;
                lp_done <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (lp_cnt == '1) begin
                    if (!lp_done) begin
                        long_q  <= 1'b1;
                        lp_done <= 1'b1;
                    end
                end else if (level) begin
                    lp_cnt <= lp_cnt + LP_W'(1);
                end
            end
        end

        assign long_v[i] = long_q;
`else
        assign long_v[i] = 1'b0;
`endif
    end

    assign bus.db_level  = level_v;
    assign bus.rise_tick = rise_v;
    assign bus.fall_tick = fall_v;
    assign bus.long_tick = long_v;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed self-checking bench for multi_debounce with CNT_W=2, LP_W=3, N_CH=4.
// Inputs change on the falling edge; outputs are sampled on later falling edges.
module tb_multi_debounce;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    multi_debounce_if #(.N_CH(4)) bus ();

    multi_debounce #(
        .N_CH (4),
        .CNT_W(2),
        .LP_W (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] db, input logic [3:0] rise,
                           input logic [3:0] fall);
        chk_vec({tag, "_db"}, bus.db_level, db);
        chk_vec({tag, "_rise"}, bus.rise_tick, rise);
        chk_vec({tag, "_fall"}, bus.fall_tick, fall);
    endtask

    initial begin
        logic [3:0] exp_long;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.sw      = 4'b0000;

        // Reset state
        wait_neg(3);
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000);
        chk_vec("reset_long", bus.long_tick, 4'b0000);

        // Release with all switches high: full latency of 8 cycles
        reset  = 1'b0;
        bus.sw = 4'b1111;
        wait_neg(7);
        chk_all("first_pre", 4'b0000, 4'b0000, 4'b0000);
        wait_neg(1);
        chk_all("first_rise", 4'b1111, 4'b1111, 4'b0000);
        wait_neg(1);
        chk_all("first_post", 4'b1111, 4'b0000, 4'b0000);

        // Asynchronous reset clears outputs before the next clock edge
        #2 reset = 1'b1;
        #1 chk_all("async_reset", 4'b0000, 4'b0000, 4'b0000);

        // Reset mid-wait: channels in WAIT1 with sw=1111
        @(negedge clk);
        reset = 1'b0;
        wait_neg(5);
        #2 reset = 1'b1;
        #1 chk_all("midwait_reset", 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        wait_neg(7);
        chk_all("midwait_pre", 4'b0000, 4'b0000, 4'b0000);
        wait_neg(1);
        chk_all("midwait_rise", 4'b1111, 4'b1111, 4'b0000);
        wait_neg(1);
        chk_all("midwait_post", 4'b1111, 4'b0000, 4'b0000);

        // Release all channels: fall path has the same latency
        bus.sw = 4'b0000;
        wait_neg(7);
        chk_all("relall_pre", 4'b1111, 4'b0000, 4'b0000);
        wait_neg(1);
        chk_all("relall_fall", 4'b0000, 4'b0000, 4'b1111);
        wait_neg(1);
        chk_all("relall_post", 4'b0000, 4'b0000, 4'b0000);

        // Clean press/release on channel 1
        bus.sw = 4'b0010;
        wait_neg(7);
        chk_all("ch1_press_pre", 4'b0000, 4'b0000, 4'b0000);
        wait_neg(1);
        chk_all("ch1_press", 4'b0010, 4'b0010, 4'b0000);
        wait_neg(1);
        chk_all("ch1_press_post", 4'b0010, 4'b0000, 4'b0000);
        wait_neg(11);
        bus.sw = 4'b0000;
        wait_neg(7);
        chk_all("ch1_rel_pre", 4'b0010, 4'b0000, 4'b0000);
        wait_neg(1);
        chk_all("ch1_rel", 4'b0000, 4'b0000, 4'b0010);
        wait_neg(1);
        chk_all("ch1_rel_post", 4'b0000, 4'b0000, 4'b0000);

        // Bounce on channel 2: 3-cycle pulses are shorter than the filter
        for (int k = 0; k < 10; k++) begin
            bus.sw[2] = ~bus.sw[2];
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk_all("bounce", 4'b0000, 4'b0000, 4'b0000);
            end
        end
        bus.sw[2] = 1'b1;
        wait_neg(7);
        chk_all("bounce_hold_pre", 4'b0000, 4'b0000, 4'b0000);
        wait_neg(1);
        chk_all("bounce_hold_rise", 4'b0100, 4'b0100, 4'b0000);
        wait_neg(1);
        chk_all("bounce_hold_post", 4'b0100, 4'b0000, 4'b0000);

        // Independence: channels 0 and 3 rise two cycles apart
        bus.sw[0] = 1'b1;
        wait_neg(2);
        bus.sw[3] = 1'b1;
        wait_neg(6);
        chk_all("indep_ch0", 4'b0101, 4'b0001, 4'b0000);
        wait_neg(1);
        chk_all("indep_gap", 4'b0101, 4'b0000, 4'b0000);
        wait_neg(1);
        chk_all("indep_ch3", 4'b1101, 4'b1000, 4'b0000);
        wait_neg(1);
        chk_all("indep_post", 4'b1101, 4'b0000, 4'b0000);

        bus.sw = 4'b0000;
        wait_neg(12);
        chk_all("clear", 4'b0000, 4'b0000, 4'b0000);

        // Long press on channel 0 with a 1-cycle glitch after the long tick
        bus.sw = 4'b0001;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
`ifdef DEBOUNCE_LONGPRESS_EN
            exp_long = (c == 16) ? 4'b0001 : 4'b0000;
`else
            exp_long = 4'b0000;
`endif
            chk_vec("long_tick", bus.long_tick, exp_long);
            if (c == 8) chk_vec("long_rise", bus.rise_tick, 4'b0001);
            if (c >= 8) chk_vec("long_db", bus.db_level, 4'b0001);
            if (c >= 9) chk_vec("long_norise", bus.rise_tick, 4'b0000);
            if (c == 20) bus.sw[0] = 1'b0;
            if (c == 21) bus.sw[0] = 1'b1;
        end
        chk_vec("long_nofall", bus.fall_tick, 4'b0000);

        bus.sw = 4'b0000;
        wait_neg(8);
        chk_all("long_release", 4'b0000, 4'b0000, 4'b0001);
        chk_vec("long_release_lt", bus.long_tick, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
